// File: rtl/mac_drv_pkg.sv
// Shared types and widths for the MAC driver slice.
package mac_drv_pkg;

  localparam int unsigned OperandWidth = 8;
  localparam int unsigned ResultWidth  = 32;
  localparam int unsigned EntryWidth   = 2 * OperandWidth;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResult
  } mac_drv_state_e;

endpackage

// File: rtl/mac_drv_fifo.sv
// Synchronous operand FIFO; pointers wrap modulo DEPTH (power of two), flush empties it.
module mac_drv_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = count_q == (PtrW + 1)'(DEPTH);
  assign empty   = count_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mac_driver.sv
// Buffers operand pairs and issues them one at a time to an external MAC, returning its total.
// Define MAC_DRV_TIMEOUT_EN to abort a MAC wait after TIMEOUT cycles (res_err flags the abort).
module mac_driver
  import mac_drv_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [OperandWidth-1:0] in_a,
  input  logic signed [OperandWidth-1:0] in_b,
  input  logic                           start,
  output logic                           busy,
  output logic                           mac_valid,
  output logic signed [OperandWidth-1:0] mac_a,
  output logic signed [OperandWidth-1:0] mac_b,
  input  logic                           mac_done,
  input  logic signed [ResultWidth-1:0]  mac_y,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [ResultWidth-1:0]  res_data,
  output logic [$clog2(DEPTH):0]         res_count,
  output logic                           res_err
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  mac_drv_state_e                 state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic signed [ResultWidth-1:0]  res_data_q, res_data_d;
  logic                           err_q, err_d;
  logic                           rdy_q;
  logic                           fifo_push, fifo_pop, fifo_flush;
  logic                           fifo_full, fifo_empty;
  logic [EntryWidth-1:0]          fifo_rdata;
  logic [CntW-1:0]                fifo_count;
  logic                           issuing;
  logic                           tmo_hit;

  mac_drv_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EntryWidth)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .wdata({in_a, in_b}),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // rdy_q keeps in_ready low during reset and for the release cycle.
  assign in_ready  = rdy_q && (state_q == StIdle) && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign busy      = state_q != StIdle;
  assign mac_valid = state_q == StIssue;
  assign issuing   = (state_q == StIssue) || (state_q == StWait);
  assign mac_a     = issuing ? fifo_rdata[EntryWidth-1:OperandWidth] : '0;
  assign mac_b     = issuing ? fifo_rdata[OperandWidth-1:0] : '0;
  assign res_valid = state_q == StResult;
  assign res_data  = res_data_q;
  assign res_count = cnt_q;
  assign res_err   = err_q;

`ifdef MAC_DRV_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  assign tmo_hit = tmo_q == TmoW'(TIMEOUT - 1);

  always_comb begin
    tmo_d = '0;
    if (state_q == StWait && !mac_done) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !fifo_empty) state_d = StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mac_done) begin
          fifo_pop = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // Head is the last pair: this mac_y is the final total.
          if (fifo_count == CntW'(1)) begin
            state_d    = StResult;
            res_data_d = mac_y;
          end else begin
            state_d = StIssue;
          end
        end else if (tmo_hit) begin
          fifo_flush = 1'b1;
          state_d    = StResult;
          res_data_d = '0;
          err_d      = 1'b1;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      res_data_q <= '0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
    end
  end

endmodule

// File: doc/mac_driver.md
MAC_DRIVER -- requirements
Module: mac_driver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of operand-pair slots in the buffer (power of two, 2..64).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles spent waiting for mac_done (used only under REQ-030).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_a input 8 signed, in_b input 8 signed: host operand-push handshake.
REQ-006 SHALL have port start  input  1  single-cycle request to issue all buffered pairs.
REQ-007 SHALL have port busy  output  1  high from accepted start until the result is consumed.
REQ-008 SHALL have ports mac_valid output 1, mac_a output 8 signed, mac_b output 8 signed: request side toward the MAC.
REQ-009 SHALL have ports mac_done input 1, mac_y input 32 signed: completion side from the MAC.
REQ-010 SHALL have ports res_valid output 1, res_ready input 1, res_data output 32 signed, res_count output $clog2(DEPTH)+1: result handshake.
REQ-011 SHALL have port res_err  output  1  result aborted by timeout; constant 0 without the REQ-030 macro.

Function
REQ-012 SHALL accept a pair when in_valid && in_ready; in_ready = buffer not full && state IDLE.
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESULT.
REQ-014 IDLE->ISSUE on start with buffer non-empty; start with empty buffer or outside IDLE SHALL be ignored.
REQ-015 ISSUE SHALL drive mac_valid=1 for exactly one cycle with the head pair on mac_a/mac_b, then go to WAIT.
REQ-016 mac_a/mac_b SHALL stay stable from the ISSUE cycle until mac_done is sampled (MAC captures operands one cycle after valid).
REQ-017 WAIT SHALL pop the head pair on mac_done, increment the issued count, and go to ISSUE if the buffer still holds pairs, otherwise to RESULT.
REQ-018 On the final mac_done, res_data SHALL register mac_y from that same cycle; res_count SHALL equal pairs issued.
REQ-019 RESULT SHALL hold res_valid=1 and stable outputs until res_ready; on res_valid && res_ready go to IDLE and clear the count.
REQ-020 mac_done outside WAIT SHALL be ignored.
REQ-021 Minimum spacing between mac_valid pulses SHALL be 1 cycle after the sampled mac_done (ISSUE immediately follows WAIT).
REQ-022 Buffer SHALL wrap read/write pointers modulo DEPTH; a full buffer holds exactly DEPTH pairs.
REQ-023 Driver SHALL NOT subtract or clear the MAC accumulator; res_data is the MAC running total as reported.

Reset
REQ-024 reset SHALL asynchronously force IDLE, empty buffer, count 0.
REQ-025 During reset: in_ready=0, busy=0, mac_valid=0, mac_a=mac_b=0, res_valid=0, res_data=0, res_count=0, res_err=0; in_ready rises the first cycle after release.
REQ-026 Reset mid-operation SHALL discard buffered pairs and any pending result without a final pulse.

Configuration
REQ-030 With MAC_DRV_TIMEOUT_EN defined, a counter in WAIT SHALL, at TIMEOUT cycles without mac_done, flush the buffer and enter RESULT with res_err=1 and res_data=0; res_err clears on consumption.
REQ-031 Without MAC_DRV_TIMEOUT_EN, WAIT SHALL wait indefinitely and res_err SHALL tie to 0.

Structure
REQ-040 Package mac_drv_pkg SHALL hold the state enum, operand width (8) and result width (32) constants.
REQ-041 Operand storage SHALL be a sub-module mac_drv_fifo (synchronous FIFO, 16-bit entries, full/empty flags).

Verification
REQ-050 Push (3,4),(-2,5),(7,-1); start; MAC model -> three single-cycle mac_valid pulses, res_data=-5, res_count=3.
REQ-051 Push DEPTH pairs -> in_ready=0; extra push with in_valid=1 not accepted; buffer contents unchanged.
REQ-052 start with empty buffer -> busy stays 0, no mac_valid.
REQ-053 Hold res_ready=0 for 5 cycles after res_valid -> res_data/res_count stable; res_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-054 Assert reset while in WAIT with 2 pairs pending -> all outputs zero immediately; buffer empty after release.
REQ-055 With MAC_DRV_TIMEOUT_EN and MAC never asserting done -> res_valid with res_err=1 after 16 WAIT cycles.
